// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : multi-cycle ALU with registered outputs and start/busy/done
//           handshake.
//
// Logic, add/sub/neg and shift/rotate ops finish on the accepting edge.
// Signed multiply (radix-2 shift-add) and signed restoring divide work on
// operand magnitudes for WIDTH iterations, then apply signs in one final
// cycle.
//
// Ports
//   clock      rising-edge clock
//   clear      asynchronous active-high reset
//   start      request, sampled only while busy = 0
//   opcode     operation select (5 bits)
//   a          operand A, shift/rotate source, dividend, multiplicand
//   b          operand B, divisor, multiplier
//   num        shift/rotate amount
//   busy       multi-cycle operation in progress
//   done       one-cycle completion pulse
//   result     low result / quotient / low product
//   result_hi  remainder / high product, 0 for all other ops
//   carry      carry out of add, NOT borrow of sub/neg
//   overflow   signed overflow of add/sub/neg
//   div_zero   last division had b = 0
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_OR  = 5'd1;
    localparam logic [4:0] OP_XOR = 5'd2;
    localparam logic [4:0] OP_NOT = 5'd3;
    localparam logic [4:0] OP_ADD = 5'd4;
    localparam logic [4:0] OP_SUB = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_SHR = 5'd9;
    localparam logic [4:0] OP_SRA = 5'd10;
    localparam logic [4:0] OP_ROL = 5'd11;
    localparam logic [4:0] OP_ROR = 5'd12;
    localparam logic [4:0] OP_NEG = 5'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             div_zero_q, div_zero_d;

    // Iterative datapath: acc holds the running high product / remainder,
    // quo holds the multiplier bits / dividend bits being turned into the
    // quotient, mag is the multiplicand or divisor magnitude.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] a_cap_q, a_cap_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             b_zero_q, b_zero_d;

    // ------------------------------------------------------------------
    // Single-cycle ALU (works directly on the inputs seen at the
    // accepting edge)
    // ------------------------------------------------------------------
    logic [SHW-1:0]     amt;
    logic               big_shift;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   sub_x, sub_y;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;

    assign amt = num[SHW-1:0];
    // WIDTH is a power of two, so num >= WIDTH exactly when any bit above
    // the amount field is set.
    assign big_shift = |num[WIDTH-1:SHW];

    // NOTE: every signal written in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;

        add_w = {1'b0, a} + {1'b0, b};
        // neg is 0 - a, so it shares the subtractor with sub.
        sub_x = (opcode == OP_NEG) ? '0 : a;
        sub_y = (opcode == OP_NEG) ? a : b;
        sub_w = {1'b0, sub_x} + {1'b0, ~sub_y} + {{WIDTH{1'b0}}, 1'b1};

        // Rotates: shift a doubled copy and keep the wrapped-around half.
        rot_l = {a, a} << amt;
        rot_r = {a, a} >> amt;

        case (opcode)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_NEG: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (sub_x[WIDTH-1] != sub_y[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != sub_x[WIDTH-1]);
            end
            OP_SHL: alu_res = big_shift ? '0 : (a << amt);
            OP_SHR: alu_res = big_shift ? '0 : (a >> amt);
            OP_SRA: alu_res = big_shift ? {WIDTH{a[WIDTH-1]}}
                                        : WIDTH'($signed(a) >>> amt);
            OP_ROL: alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR: alu_res = rot_r[WIDTH-1:0];
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration and sign-fix helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // |MIN| does not fit as a signed value but is exact as an unsigned one.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set; the carry bit is shifted down into acc.
    assign mul_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, mag_q} : '0);

    // Restoring step: bring the next dividend bit into the remainder and
    // try the subtraction; bit WIDTH of the difference is its sign.
    assign div_shift = {acc_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};

    assign prod     = {acc_q, quo_q};
    assign prod_fix = neg_lo_q ? -prod : prod;
    assign quo_fix  = neg_lo_q ? -quo_q : quo_q;
    assign rem_fix  = neg_hi_q ? -acc_q : acc_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        acc_d       = acc_q;
        quo_d       = quo_q;
        mag_d       = mag_q;
        a_cap_d     = a_cap_q;
        is_div_d    = is_div_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        b_zero_d    = b_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL || opcode == OP_DIV) begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        is_div_d = (opcode == OP_DIV);
                        acc_d    = '0;
                        mag_d    = (opcode == OP_DIV) ? abs_b : abs_a;
                        quo_d    = (opcode == OP_DIV) ? abs_a : abs_b;
                        a_cap_d  = a;
                        neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_hi_d = a[WIDTH-1];
                        b_zero_d = (b == '0);
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        carry_d     = alu_c;
                        overflow_d  = alu_v;
                        div_zero_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                // WIDTH - 1 is all ones, so the counter wraps back to 0
                // on the last iteration.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (is_div_q && b_zero_q) begin
                    result_d    = '1;
                    result_hi_d = a_cap_q;
                end else if (is_div_q) begin
                    result_d    = quo_fix;
                    result_hi_d = rem_fix;
                end else begin
                    result_d    = prod_fix[WIDTH-1:0];
                    result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                carry_d    = 1'b0;
                overflow_d = 1'b0;
                div_zero_d = is_div_q && b_zero_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            acc_q       <= '0;
            quo_q       <= '0;
            mag_q       <= '0;
            a_cap_q     <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            b_zero_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            mag_q       <= mag_d;
            a_cap_q     <= a_cap_d;
            is_div_q    <= is_div_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            b_zero_q    <= b_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu : self-checking bench for seq_alu.
//
// Two instances: WIDTH = 32 (main) and WIDTH = 8 (parameter check).
// Expected values come from a behavioural model using plain wide integer
// arithmetic (signed multiply, / and % on 64-bit integers).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_alu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clear;

    logic        start32, start8;
    logic [4:0]  op32, op8;
    logic [31:0] a32, b32, n32;
    logic [7:0]  a8, b8, n8;

    logic        busy32, done32, c32, v32, dz32;
    logic [31:0] res32, hi32;
    logic        busy8, done8, c8, v8, dz8;
    logic [7:0]  res8, hi8;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start32), .opcode(op32),
        .a(a32), .b(b32), .num(n32),
        .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
        .carry(c32), .overflow(v32), .div_zero(dz32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .opcode(op8),
        .a(a8), .b(b8), .num(n8),
        .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
        .carry(c8), .overflow(v8), .div_zero(dz8)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] hi;
        logic        c;
        logic        v;
        logic        dz;
    } out_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] mask_of(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Behavioural reference: results straight from the arithmetic rules.
    function automatic out_t model(int w, logic [4:0] op, logic [63:0] a, logic [63:0] b,
                                   logic [63:0] num);
        logic [63:0] m;
        longint      sa, sb, t, hi_lim, lo_lim;
        int          k;
        out_t        o;
        m      = mask_of(w);
        sa     = a[w-1] ? $signed(a | ~m) : $signed(a);
        sb     = b[w-1] ? $signed(b | ~m) : $signed(b);
        hi_lim = (longint'(1) << (w - 1)) - 1;
        lo_lim = -(longint'(1) << (w - 1));
        k      = int'(num % 64'(w));
        o      = '0;
        case (op)
            5'd0: o.res = a & b;
            5'd1: o.res = a | b;
            5'd2: o.res = a ^ b;
            5'd3: o.res = ~a & m;
            5'd4: begin
                o.res = (a + b) & m;
                o.c   = ((a + b) >> w) != 0;
                t     = sa + sb;
                o.v   = (t > hi_lim) || (t < lo_lim);
            end
            5'd5: begin
                o.res = (a - b) & m;
                o.c   = (a >= b);
                t     = sa - sb;
                o.v   = (t > hi_lim) || (t < lo_lim);
            end
            5'd13: begin
                o.res = (64'd0 - a) & m;
                o.c   = (a == 0);
                t     = -sa;
                o.v   = (t > hi_lim) || (t < lo_lim);
            end
            5'd8:  o.res = (num >= 64'(w)) ? 64'd0 : ((a << num) & m);
            5'd9:  o.res = (num >= 64'(w)) ? 64'd0 : (a >> num);
            5'd10: o.res = (num >= 64'(w)) ? (a[w-1] ? m : 64'd0) : (64'(sa >>> num) & m);
            5'd11: o.res = ((a << k) | (a >> (w - k))) & m;
            5'd12: o.res = ((a >> k) | (a << (w - k))) & m;
            5'd6: begin
                t     = sa * sb;
                o.res = 64'(t) & m;
                o.hi  = (64'(t) >> w) & m;
            end
            5'd7: begin
                if (b == 0) begin
                    o.res = m;
                    o.hi  = a;
                    o.dz  = 1'b1;
                end else begin
                    o.res = 64'(sa / sb) & m;
                    o.hi  = 64'(sa % sb) & m;
                end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic out_t observed(int w);
        out_t o;
        if (w == 32) begin
            o.res = {32'd0, res32}; o.hi = {32'd0, hi32};
            o.c = c32; o.v = v32; o.dz = dz32;
        end else begin
            o.res = {56'd0, res8}; o.hi = {56'd0, hi8};
            o.c = c8; o.v = v8; o.dz = dz8;
        end
        return o;
    endfunction

    function automatic logic done_w(int w);
        return (w == 32) ? done32 : done8;
    endfunction

    function automatic logic busy_w(int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    task automatic drive(input int w, input logic s, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] num);
        if (w == 32) begin
            start32 = s; op32 = op; a32 = a[31:0]; b32 = b[31:0]; n32 = num[31:0];
        end else begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0]; n8 = num[7:0];
        end
    endtask

    task automatic check_outputs(input string tag, input int w, input out_t e);
        out_t o;
        o = observed(w);
        check({tag, ".result"},    o.res, e.res);
        check({tag, ".result_hi"}, o.hi,  e.hi);
        check({tag, ".carry"},     64'(o.c),  64'(e.c));
        check({tag, ".overflow"},  64'(o.v),  64'(e.v));
        check({tag, ".div_zero"},  64'(o.dz), 64'(e.dz));
    endtask

    function automatic logic [63:0] rand_val(int w);
        logic [63:0] m;
        m = mask_of(w);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {32'd0, $urandom} & m;
        endcase
    endfunction

    function automatic logic [63:0] rand_num(int w);
        if ($urandom_range(0, 3) == 0) return {32'd0, $urandom} & mask_of(w);
        return 64'($urandom_range(0, 2 * w));
    endfunction

    // Issue one op, scramble the inputs right after acceptance, and wait
    // for done. done_edges counts edges after the accepting edge at which
    // done appears (0 for single-cycle ops, WIDTH+1 for mul/div).
    task automatic run_op(input string tag, input int w, input logic [4:0] op,
                          input logic [63:0] a_in, input logic [63:0] b_in,
                          input logic [63:0] n_in);
        out_t        e;
        logic [63:0] m;
        int          done_edges, busy_cycles;
        logic        multi;
        m     = mask_of(w);
        e     = model(w, op, a_in & m, b_in & m, n_in & m);
        multi = (op == 5'd6) || (op == 5'd7);
        @(negedge clock);
        drive(w, 1'b1, op, a_in & m, b_in & m, n_in & m);
        @(negedge clock);
        drive(w, 1'b0, 5'($urandom), {32'd0, $urandom}, {32'd0, $urandom}, {32'd0, $urandom});
        done_edges  = 0;
        busy_cycles = 0;
        while (!done_w(w) && done_edges < 200) begin
            if (busy_w(w)) busy_cycles++;
            @(negedge clock);
            done_edges++;
        end
        check({tag, ".done_seen"}, 64'(done_w(w)), 64'd1);
        check({tag, ".latency"}, 64'(done_edges), multi ? 64'(w + 1) : 64'd0);
        check({tag, ".busy_cycles"}, 64'(busy_cycles), multi ? 64'(w + 1) : 64'd0);
        check({tag, ".busy_at_done"}, 64'(busy_w(w)), 64'd0);
        check_outputs(tag, w, e);
        @(negedge clock);
        check({tag, ".done_width"}, 64'(done_w(w)), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_t        e, prev;
        logic        have_prev;
        logic [4:0]  op;
        logic [63:0] ra, rb, rn;
        int          n_done, cycles;
        logic [31:0] seen_res;

        clear = 1'b1;
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        drive(8,  1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        repeat (2) @(negedge clock);
        check_outputs("reset32", 32, '0);
        check("reset32.busy", 64'(busy32), 64'd0);
        check("reset32.done", 64'(done32), 64'd0);
        check_outputs("reset8", 8, '0);
        check("reset8.busy", 64'(busy8), 64'd0);
        clear = 1'b0;

        // Directed single-cycle boundary cases.
        run_op("add_min_min", 32, 5'd4, 64'h8000_0000, 64'h8000_0000, 64'd0);
        check("add_min_min.carry_const", 64'(c32), 64'd1);
        check("add_min_min.ovf_const", 64'(v32), 64'd1);
        run_op("sub_0_1", 32, 5'd5, 64'd0, 64'd1, 64'd0);
        check("sub_0_1.result_const", 64'(res32), 64'hFFFF_FFFF);
        run_op("sra_40", 32, 5'd10, 64'h8000_0000, 64'd0, 64'd40);
        check("sra_40.result_const", 64'(res32), 64'hFFFF_FFFF);
        run_op("rol_33", 32, 5'd11, 64'h8000_0001, 64'd0, 64'd33);
        check("rol_33.result_const", 64'(res32), 64'h0000_0003);
        run_op("shl_32", 32, 5'd8, 64'hFFFF_FFFF, 64'd0, 64'd32);
        run_op("neg_min", 32, 5'd13, 64'h8000_0000, 64'd0, 64'd0);
        run_op("neg_zero", 32, 5'd13, 64'd0, 64'd0, 64'd0);

        // Directed multi-cycle cases.
        run_op("mul_m3_7", 32, 5'd6, 64'hFFFF_FFFD, 64'd7, 64'd0);
        check("mul_m3_7.result_const", 64'(res32), 64'hFFFF_FFEB);
        check("mul_m3_7.hi_const", 64'(hi32), 64'hFFFF_FFFF);
        run_op("div_m7_2", 32, 5'd7, 64'hFFFF_FFF9, 64'd2, 64'd0);
        check("div_m7_2.result_const", 64'(res32), 64'hFFFF_FFFD);
        run_op("div_5_0", 32, 5'd7, 64'd5, 64'd0, 64'd0);
        check("div_5_0.dz_const", 64'(dz32), 64'd1);
        run_op("div_min_m1", 32, 5'd7, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
        run_op("and_clears_dz", 32, 5'd0, 64'hF0F0, 64'hFF00, 64'd0);

        // Reset in the middle of a division.
        run_op("pre_clear", 32, 5'd5, 64'd0, 64'd1, 64'd0);
        @(negedge clock);
        drive(32, 1'b1, 5'd7, 64'd100, 64'd7, 64'd0);
        @(negedge clock);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        repeat (9) @(negedge clock);
        check("mid_div.busy_before", 64'(busy32), 64'd1);
        clear = 1'b1;
        #1;
        check_outputs("mid_div.cleared", 32, '0);
        check("mid_div.busy_cleared", 64'(busy32), 64'd0);
        check("mid_div.done_cleared", 64'(done32), 64'd0);
        @(negedge clock);
        clear  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (done32) n_done++;
        end
        check("mid_div.no_done", 64'(n_done), 64'd0);
        run_op("after_clear_add", 32, 5'd4, 64'd1, 64'd2, 64'd0);
        check("after_clear_add.result_const", 64'(res32), 64'd3);

        // A start during a multiply is dropped.
        @(negedge clock);
        drive(32, 1'b1, 5'd6, 64'd5, 64'd6, 64'd0);
        @(negedge clock);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        @(negedge clock);
        drive(32, 1'b1, 5'd0, 64'hF, 64'h3, 64'd0);
        @(negedge clock);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        n_done   = 0;
        seen_res = '0;
        repeat (45) begin
            @(negedge clock);
            if (done32) begin
                n_done++;
                seen_res = res32;
            end
        end
        check("drop.done_count", 64'(n_done), 64'd1);
        check("drop.result", 64'(seen_res), 64'd30);

        // Start accepted in the done cycle.
        @(negedge clock);
        drive(32, 1'b1, 5'd6, 64'hFFFF_FFFE, 64'd9, 64'd0);
        @(negedge clock);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        cycles = 0;
        while (!done32 && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
        check("b2b.first_done", 64'(done32), 64'd1);
        check_outputs("b2b.mul", 32, model(32, 5'd6, 64'hFFFF_FFFE, 64'd9, 64'd0));
        drive(32, 1'b1, 5'd4, 64'h10, 64'h20, 64'd0);
        @(negedge clock);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);
        check("b2b.second_done", 64'(done32), 64'd1);
        check("b2b.second_result", 64'(res32), 64'h30);
        check("b2b.second_hi", 64'(hi32), 64'd0);
        @(negedge clock);
        check("b2b.done_drops", 64'(done32), 64'd0);
        check("b2b.result_holds", 64'(res32), 64'h30);

        // Random single-cycle ops issued every cycle.
        have_prev = 1'b0;
        prev      = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (have_prev) begin
                check_outputs("burst", 32, prev);
                check("burst.done", 64'(done32), 64'd1);
                check("burst.busy", 64'(busy32), 64'd0);
            end
            op = 5'($urandom_range(0, 31));
            while (op == 5'd6 || op == 5'd7) op = 5'($urandom_range(0, 31));
            ra = rand_val(32);
            rb = rand_val(32);
            rn = rand_num(32);
            drive(32, 1'b1, op, ra, rb, rn);
            prev      = model(32, op, ra, rb, rn);
            have_prev = 1'b1;
        end
        @(negedge clock);
        check_outputs("burst", 32, prev);
        drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0);

        // Random multiply / divide at both widths.
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
            run_op(op == 5'd6 ? "rand_mul32" : "rand_div32", 32, op,
                   rand_val(32), rand_val(32), 64'd0);
        end

        // WIDTH = 8 instance.
        run_op("w8_mul_min_min", 8, 5'd6, 64'h80, 64'h80, 64'd0);
        check("w8_mul_min_min.product_const", {48'd0, hi8, res8}, 64'h4000);
        run_op("w8_invalid_20", 8, 5'd20, 64'h5A, 64'h33, 64'd3);
        for (int i = 0; i < 24; i++) begin
            op = 5'($urandom_range(4, 13));
            run_op("rand_w8", 8, op, rand_val(8), rand_val(8), rand_num(8));
        end
        e = model(8, 5'd7, 64'h80, 64'hFF, 64'd0);
        run_op("w8_div_min_m1", 8, 5'd7, 64'h80, 64'hFF, 64'd0);
        check("w8_div_min_m1.result_const", 64'(res8), e.res);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU that replaces the purely combinational ALU in the datapath. It adds registered outputs, a start/busy/done handshake, arithmetic ops (add, sub, negate), an iterative signed multiplier and an iterative signed divider. It sits between the register-file read ports and the Z/HI/LO writeback registers. The control unit pulses `start` and waits for `done` before latching results.

## Interface
- `WIDTH`, 32: operand and result width in bits. Must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): number of shift-amount bits used from `num`.
- `clock` in 1: rising-edge clock.
- `clear` in 1: reset, asynchronous, active-high.
- `start` in 1: request. Sampled only when `busy`=0.
- `opcode` in 5: operation select.
- `a` in WIDTH: operand A. Shift/rotate source.
- `b` in WIDTH: operand B. Divisor, multiplier.
- `num` in WIDTH: shift/rotate amount.
- `busy` out 1: operation in progress. New `start` is ignored.
- `done` out 1: one-cycle pulse. `result`, `result_hi` and the flags are valid from this cycle on.
- `result` out WIDTH: low result, quotient, or low product.
- `result_hi` out WIDTH: remainder or high product; 0 for all other ops.
- `carry` out 1: carry out of add; NOT borrow for sub.
- `overflow` out 1: signed overflow of add/sub/neg.
- `div_zero` out 1: last division had `b`=0.

## Operation
- Opcodes:
  - Single-cycle class: 0 and, 1 or, 2 xor, 3 not a, 4 add, 5 sub (a−b), 8 shl, 9 shr (logical), 10 sra, 11 rol, 12 ror, 13 neg (0−a).
  - Multi-cycle class: 6 mul, 7 div.
  - Any other opcode is single-cycle and yields all outputs 0.
- Operands are captured internally on the accepting edge. Input changes afterwards have no effect.
- Shifts:
  - The amount is `num[SHW-1:0]` when `num` < WIDTH.
  - shl/shr with `num` ≥ WIDTH give 0; sra with `num` ≥ WIDTH gives all sign bits.
  - Rotates use `num` mod WIDTH.
- Flags:
  - `carry` and `overflow` are updated only by ops 4/5/13.
  - `div_zero` is updated only by op 7.
  - All other ops clear these flags.
- mul:
  - Signed two's-complement, 2·WIDTH-bit product: `result_hi:result`.
  - Radix-2 shift-add on magnitudes, sign fixed in a final cycle.
- div:
  - Signed restoring division, quotient truncated toward zero; remainder takes the sign of `a`.
  - `b`=0: `result`=all ones, `result_hi`=`a`, `div_zero`=1.
  - MIN / −1: `result`=MIN, `result_hi`=0, no flag.
- State machine: IDLE → RUN (WIDTH iterations, counter 0..WIDTH−1) → FIX → IDLE.
  - Single-cycle ops stay in IDLE.
  - div by zero still traverses RUN and FIX, so latency is constant.
- Outputs hold their last values until the next completion.

## Timing
- Reset (async, any state): state=IDLE, counter=0, `busy`=0, `done`=0, `result`=0, `result_hi`=0, `carry`=0, `overflow`=0, `div_zero`=0.
- `clear` asserted mid-operation aborts it; no `done` follows.
- Single-cycle op accepted at edge k:
  - Outputs and `done`=1 are registered at edge k (latency 1).
  - `busy` stays 0.
- mul/div accepted at edge k:
  - `busy`=1 from edge k.
  - Iterations occur on edges k+1..k+WIDTH.
  - Edge k+WIDTH+1 writes outputs, sets `done`=1 and sets `busy`=0. Latency is WIDTH+1; 33 for WIDTH=32.
- `done` is exactly one cycle wide. It clears on the next edge unless another single-cycle op completes on that edge.
- Back-to-back: `start` is accepted in the same cycle `done` is high, since `busy`=0. Single-cycle ops issue every cycle.
- `start` while `busy`=1 is dropped silently; no queueing.

## Test plan
- Reset mid-div: start op 7, a=100, b=7; assert `clear` at cycle 10 → all outputs 0 immediately, no `done`. Next op 4 with a=1, b=2 → `result`=3 after 1 cycle.
- Single-cycle sweep, WIDTH=32, a=0x8000_0000, b=0x8000_0000:
  - add → `result`=0, `carry`=1, `overflow`=1.
  - sub with a=0, b=1 → 0xFFFF_FFFF, `carry`=0.
  - sra with a=0x8000_0000, `num`=40 → 0xFFFF_FFFF.
  - rol with a=0x8000_0001, `num`=33 → 0x0000_0003.
- mul: a=−3, b=7 → after 33 cycles `result`=0xFFFF_FFEB, `result_hi`=0xFFFF_FFFF, `busy` high for exactly 33 cycles.
- div:
  - a=−7, b=2 → `result`=−3, `result_hi`=−1.
  - a=5, b=0 → `result`=0xFFFF_FFFF, `result_hi`=5, `div_zero`=1, latency 33.
- Handshake: second `start` (op 0) issued during a mul → ignored, only one `done`. `start` issued in the `done` cycle → accepted, next `done` one cycle later.
- Parameter: WIDTH=8, mul a=−128, b=−128 → `result_hi:result`=0x4000 after 9 cycles. Invalid opcode 20 → all outputs 0, `done` pulse.
